seg_frame_decoder: RTL and testbench

- Evaluator-side reader for the garbled display output: consumes the pixel bitmaps produced by the display circuit, one pixel per beat, and recovers the segment message.
- Segments are shown stochastically (LFSR probability, ≈0.7 ON for shown segments), so the block accumulates per-segment hit counts over NB_FRAMES frames and majority-decides each segment.
- Used in the bench/demo path to check garbled display output against the garbler's msg. It is also the decoder counterpart of segment2pixel.

---
 rtl/display_pkg.sv | 13 +
 rtl/pix2seg_map.sv | 19 +
 rtl/seg_frame_decoder.sv | 103 ++++++++++
 tb/tb_seg_frame_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared display geometry defaults, segment-index encoding and decoder states
package display_pkg;
  localparam int WIDTH_D = 120;
  localparam int HEIGHT_D = 52;
  localparam int NB_SEGMENTS_D = 70;
  function automatic int seg_w(input int n);
    return $clog2(n + 1);
  endfunction
  localparam int SEG_W_D = seg_w(NB_SEGMENTS_D);
  typedef logic [SEG_W_D-1:0] seg_idx_t;
  localparam seg_idx_t SEG_NONE = '1;
  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} dec_state_t;
endpackage

// File: rtl/pix2seg_map.sv
// pix2seg_map: combinational pixel-index to segment-index lookup (all-ones = no segment)
module pix2seg_map import display_pkg::*; #(
  parameter int NB_PIX = WIDTH_D * HEIGHT_D,
  parameter int NB_SEGMENTS = NB_SEGMENTS_D,
  parameter int SEG_PIX = NB_PIX / NB_SEGMENTS,
  parameter int EXTRA_PIX = 0,
  parameter int EXTRA_SEG = -1,
  localparam int PW = $clog2(NB_PIX),
  localparam int SW = seg_w(NB_SEGMENTS)
) (
  input  logic [PW-1:0] i_pix_idx,
  output logic [SW-1:0] o_seg
);
  logic [31:0] w_idx;
  assign w_idx = 32'(i_pix_idx);
  // segments own contiguous runs of SEG_PIX pixels; one extra pixel may be remapped to any segment
  assign o_seg = (EXTRA_SEG >= 0 && w_idx == EXTRA_PIX) ? SW'(EXTRA_SEG)
               : (w_idx < NB_SEGMENTS * SEG_PIX) ? SW'(w_idx / SEG_PIX) : '1;
endmodule

// File: rtl/seg_frame_decoder.sv
// seg_frame_decoder: accumulates per-segment hits over NB_FRAMES pixel frames and majority-decides the message
module seg_frame_decoder import display_pkg::*; #(
  parameter int WIDTH = WIDTH_D,
  parameter int HEIGHT = HEIGHT_D,
  parameter int NB_SEGMENTS = NB_SEGMENTS_D,
  parameter int NB_FRAMES = 8,
  parameter int THRESHOLD = 4,
  parameter int SEG_PIX = (WIDTH * HEIGHT) / NB_SEGMENTS,
  parameter int EXTRA_PIX = 0,
  parameter int EXTRA_SEG = -1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic                   pix_sof,
  input  logic                   pix_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [NB_SEGMENTS-1:0] res_msg,
  output logic                   sof_err
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int PW = $clog2(NPIX);
  localparam int HW = $clog2(NB_FRAMES + 1);
  localparam int SW = seg_w(NB_SEGMENTS);
  dec_state_t r_state;
  logic [PW-1:0] r_pix_idx, w_idx;
  logic [HW-1:0] r_frame_cnt;
  logic [NB_SEGMENTS-1:0] r_seen, w_seen_next, w_msg;
  logic [HW-1:0] r_hits [NB_SEGMENTS];
  logic [HW-1:0] w_hits_next [NB_SEGMENTS];
  logic [SW-1:0] w_seg;
  logic w_acc, w_drop, w_resync, w_last, w_frame_last;
  assign w_acc = pix_valid & pix_ready;
  assign w_drop = (r_pix_idx == '0) & ~pix_sof;
  assign w_resync = pix_sof & (r_pix_idx != '0);
  assign w_idx = w_resync ? '0 : r_pix_idx;
  assign w_last = w_idx == PW'(NPIX - 1);
  assign w_frame_last = r_frame_cnt == HW'(NB_FRAMES - 1);
  pix2seg_map #(
    .NB_PIX(NPIX), .NB_SEGMENTS(NB_SEGMENTS), .SEG_PIX(SEG_PIX),
    .EXTRA_PIX(EXTRA_PIX), .EXTRA_SEG(EXTRA_SEG)
  ) u_map (.i_pix_idx(w_idx), .o_seg(w_seg));
  // the beat being accepted is folded in before the frame-end hit update
  always_comb begin
    w_seen_next = '0;
    w_msg = '0;
    w_hits_next = '{default: '0};
    for (int s = 0; s < NB_SEGMENTS; s++) begin
      w_seen_next[s] = (~w_resync & r_seen[s]) | (pix_data & (w_seg == SW'(s)));
      w_hits_next[s] = r_hits[s] + HW'(w_seen_next[s]);
      w_msg[s] = 32'(w_hits_next[s]) >= THRESHOLD;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      pix_ready <= 1'b0;
      res_valid <= 1'b0;
      res_msg <= '0;
      sof_err <= 1'b0;
      r_pix_idx <= '0;
      r_frame_cnt <= '0;
      r_seen <= '0;
      r_hits <= '{default: '0};
    end else if (start) begin
      r_state <= ACCUM;
      pix_ready <= 1'b1;
      res_valid <= 1'b0;
      sof_err <= 1'b0;
      r_pix_idx <= '0;
      r_frame_cnt <= '0;
      r_seen <= '0;
      r_hits <= '{default: '0};
    end else if (r_state == ACCUM && w_acc) begin
      if (w_drop) begin
        sof_err <= 1'b1;
      end else begin
        if (w_resync) sof_err <= 1'b1;
        if (w_last) begin
          r_hits <= w_hits_next;
          r_seen <= '0;
          r_pix_idx <= '0;
          r_frame_cnt <= r_frame_cnt + HW'(1);
          if (w_frame_last) begin
            r_state <= RESULT;
            pix_ready <= 1'b0;
            res_valid <= 1'b1;
            res_msg <= w_msg;
          end
        end else begin
          r_seen <= w_seen_next;
          r_pix_idx <= w_idx + PW'(1);
        end
      end
    end else if (r_state == RESULT && res_ready) begin
      r_state <= IDLE;
      res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seg_frame_decoder.sv
// tb_seg_frame_decoder: scoreboard bench on a 4x2 bitmap, two segments, 4 frames, threshold 3
module tb_seg_frame_decoder;
  logic clk = 0, rst = 1, start = 0, pix_valid = 0, pix_sof = 0, pix_data = 0, res_ready = 0;
  logic pix_ready, res_valid, sof_err, pix_ready_v, res_valid_v, sof_err_v;
  logic [1:0] res_msg, res_msg_v;
  int n_cmp = 0, n_err = 0;
  logic [1:0] exp_q[$], exp_v_q[$];
  always #5 clk = ~clk;
  seg_frame_decoder #(.WIDTH(4), .HEIGHT(2), .NB_SEGMENTS(2), .NB_FRAMES(4), .THRESHOLD(3), .SEG_PIX(2)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_data(pix_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_msg(res_msg), .sof_err(sof_err));
  // variant map: the last pixel (7) also belongs to seg1
  seg_frame_decoder #(.WIDTH(4), .HEIGHT(2), .NB_SEGMENTS(2), .NB_FRAMES(4), .THRESHOLD(3), .SEG_PIX(2),
    .EXTRA_PIX(7), .EXTRA_SEG(1)) dut_v (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready_v),
    .pix_sof(pix_sof), .pix_data(pix_data), .res_valid(res_valid_v), .res_ready(res_ready),
    .res_msg(res_msg_v), .sof_err(sof_err_v));
  function automatic logic [1:0] model(input logic [7:0] fr[4], input bit v);
    int h0 = 0, h1 = 0;
    for (int f = 0; f < 4; f++) begin
      h0 += int'(fr[f][0] | fr[f][1]);
      h1 += int'(fr[f][2] | fr[f][3] | (v & fr[f][7]));
    end
    return {h1 >= 3, h0 >= 3};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic beat(input logic s, input logic d);
    pix_valid = 1;
    pix_sof = s;
    pix_data = d;
    tick();
    pix_valid = 0;
    pix_sof = 0;
    pix_data = 0;
  endtask
  task automatic send_frame(input logic [7:0] f);
    for (int i = 0; i < 8; i++) beat(i == 0, f[i]);
  endtask
  task automatic run_frames(input logic [7:0] fr[4]);
    exp_q.push_back(model(fr, 0));
    exp_v_q.push_back(model(fr, 1));
    for (int f = 0; f < 4; f++) send_frame(fr[f]);
  endtask
  task automatic get_result(output logic [1:0] m, output logic [1:0] mv, output bit got);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid && res_valid_v) begin
        got = 1;
        break;
      end
      tick();
    end
    m = res_msg;
    mv = res_msg_v;
    if (got) begin
      res_ready = 1;
      tick();
      res_ready = 0;
    end
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    rst = 0;
    tick();
    n_cmp++; if (pix_ready !== 0) begin n_err++; $display("FAIL reset_pix_ready got=%b want=0", pix_ready); end
    n_cmp++; if (res_valid !== 0) begin n_err++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    n_cmp++; if (res_msg !== 2'b00) begin n_err++; $display("FAIL reset_res_msg got=%b want=00", res_msg); end
    n_cmp++; if (sof_err !== 0) begin n_err++; $display("FAIL reset_sof_err got=%b want=0", sof_err); end
  endtask
  task automatic test_all_on();
    logic [7:0] fr[4] = '{8'h05, 8'h05, 8'h05, 8'h05};
    logic [1:0] m, mv, e, ev;
    bit got;
    do_start();
    n_cmp++; if (pix_ready !== 1) begin n_err++; $display("FAIL accum_pix_ready got=%b want=1", pix_ready); end
    exp_q.push_back(model(fr, 0));
    exp_v_q.push_back(model(fr, 1));
    for (int f = 0; f < 3; f++) send_frame(fr[f]);
    for (int i = 0; i < 7; i++) beat(i == 0, fr[3][i]);
    n_cmp++; if (res_valid !== 0) begin n_err++; $display("FAIL early_res_valid got=%b want=0", res_valid); end
    beat(0, fr[3][7]);
    n_cmp++; if (res_valid !== 1) begin n_err++; $display("FAIL latency_res_valid got=%b want=1", res_valid); end
    n_cmp++; if (pix_ready !== 0) begin n_err++; $display("FAIL result_pix_ready got=%b want=0", pix_ready); end
    get_result(m, mv, got);
    e = exp_q.pop_front();
    ev = exp_v_q.pop_front();
    n_cmp++; if (!got || m !== e) begin n_err++; $display("FAIL all_on_msg got=%b valid=%0d want=%b", m, got, e); end
    n_cmp++; if (!got || mv !== ev) begin n_err++; $display("FAIL all_on_msg_v got=%b want=%b", mv, ev); end
  endtask
  task automatic test_threshold();
    logic [7:0] fr[4] = '{8'h05, 8'h05, 8'h01, 8'h00};
    logic [1:0] m, mv, e;
    bit got;
    do_start();
    run_frames(fr);
    get_result(m, mv, got);
    e = exp_q.pop_front();
    void'(exp_v_q.pop_front());
    n_cmp++; if (!got || m !== e) begin n_err++; $display("FAIL threshold_msg got=%b want=%b", m, e); end
  endtask
  task automatic test_none_last();
    logic [7:0] fr[4] = '{8'hF2, 8'hF2, 8'hF2, 8'hF2};
    logic [1:0] m, mv, e, ev;
    bit got;
    do_start();
    run_frames(fr);
    get_result(m, mv, got);
    e = exp_q.pop_front();
    ev = exp_v_q.pop_front();
    n_cmp++; if (!got || m !== e) begin n_err++; $display("FAIL none_pix_msg got=%b want=%b", m, e); end
    n_cmp++; if (!got || mv !== ev) begin n_err++; $display("FAIL last_pix_msg_v got=%b want=%b", mv, ev); end
  endtask
  task automatic test_sof_drop();
    logic [7:0] fr[4] = '{8'h0C, 8'h0C, 8'h0C, 8'h0C};
    logic [1:0] m, mv, e;
    bit got;
    do_start();
    beat(0, 1);
    n_cmp++; if (sof_err !== 1) begin n_err++; $display("FAIL drop_sof_err got=%b want=1", sof_err); end
    run_frames(fr);
    get_result(m, mv, got);
    e = exp_q.pop_front();
    void'(exp_v_q.pop_front());
    n_cmp++; if (!got || m !== e) begin n_err++; $display("FAIL drop_msg got=%b want=%b", m, e); end
  endtask
  task automatic test_sof_resync();
    logic [7:0] fr[4] = '{8'h05, 8'h01, 8'h01, 8'h05};
    logic [1:0] m, mv, e;
    bit got;
    do_start();
    n_cmp++; if (sof_err !== 0) begin n_err++; $display("FAIL start_clears_sof_err got=%b want=0", sof_err); end
    exp_q.push_back(model(fr, 0));
    send_frame(fr[0]);
    beat(1, 0);
    beat(0, 0);
    beat(0, 1);
    beat(1, fr[1][0]);
    n_cmp++; if (sof_err !== 1) begin n_err++; $display("FAIL resync_sof_err got=%b want=1", sof_err); end
    for (int i = 1; i < 8; i++) beat(0, fr[1][i]);
    send_frame(fr[2]);
    send_frame(fr[3]);
    get_result(m, mv, got);
    e = exp_q.pop_front();
    n_cmp++; if (!got || m !== e) begin n_err++; $display("FAIL resync_msg got=%b want=%b", m, e); end
  endtask
  task automatic test_hold();
    logic [7:0] fr[4] = '{8'h05, 8'h04, 8'h05, 8'h05};
    logic [1:0] m, mv, e;
    bit got;
    do_start();
    run_frames(fr);
    e = exp_q.pop_front();
    void'(exp_v_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (res_valid !== 1 || res_msg !== e || pix_ready !== 0) begin
        n_err++; $display("FAIL hold_cycle%0d valid=%b msg=%b ready=%b want 1/%b/0", i, res_valid, res_msg, pix_ready, e);
      end
      tick();
    end
    get_result(m, mv, got);
    n_cmp++; if (!got || m !== e) begin n_err++; $display("FAIL hold_msg got=%b want=%b", m, e); end
    n_cmp++; if (res_valid !== 0 || pix_ready !== 0) begin n_err++; $display("FAIL idle_after_ack valid=%b ready=%b want 0/0", res_valid, pix_ready); end
    n_cmp++; if (res_msg !== e) begin n_err++; $display("FAIL msg_retained got=%b want=%b", res_msg, e); end
  endtask
  task automatic test_start_abort();
    logic [7:0] fr[4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    do_start();
    beat(0, 0);
    for (int f = 0; f < 4; f++) send_frame(fr[f]);
    n_cmp++; if (res_valid !== 1) begin n_err++; $display("FAIL abort_pre_valid got=%b want=1", res_valid); end
    do_start();
    n_cmp++; if (res_valid !== 0 || pix_ready !== 1 || sof_err !== 0) begin
      n_err++; $display("FAIL abort_state valid=%b ready=%b sof_err=%b want 0/1/0", res_valid, pix_ready, sof_err);
    end
  endtask
  task automatic test_rst_midframe();
    logic [7:0] fr[4] = '{8'h03, 8'h03, 8'h0F, 8'h03};
    logic [1:0] m, mv, e;
    bit got;
    do_start();
    beat(0, 1);
    send_frame(8'h0F);
    send_frame(8'h0F);
    for (int i = 0; i < 5; i++) beat(i == 0, 1);
    rst = 1;
    pix_valid = 1;
    pix_data = 1;
    tick();
    rst = 0;
    pix_valid = 0;
    pix_data = 0;
    n_cmp++; if (pix_ready !== 0 || res_valid !== 0 || res_msg !== 2'b00 || sof_err !== 0) begin
      n_err++; $display("FAIL rst_outputs ready=%b valid=%b msg=%b sof_err=%b want all 0", pix_ready, res_valid, res_msg, sof_err);
    end
    do_start();
    run_frames(fr);
    get_result(m, mv, got);
    e = exp_q.pop_front();
    void'(exp_v_q.pop_front());
    n_cmp++; if (!got || m !== e) begin n_err++; $display("FAIL post_rst_msg got=%b want=%b", m, e); end
  endtask
  initial begin
    test_reset();
    test_all_on();
    test_threshold();
    test_none_last();
    test_sof_drop();
    test_sof_resync();
    test_hold();
    test_start_abort();
    test_rst_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
